// File: rtl/mips_ans_monitor.sv
// Change-capture FIFO for the MIPS core's ans bus: each new ans value is queued and
// streamed out on valid/ready. Optional feature macro: ANS_TIMESTAMP_EN (per-entry cycle stamp).
module mips_ans_monitor #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] ans,
  input  logic          en,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          drop
`ifdef ANS_TIMESTAMP_EN
  ,
  output logic [15:0]   out_ts
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] prev;
  logic          prev_vld;
  logic          cap;
  logic          pop;
  logic          push;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign out_valid = ~empty;
  // Gate the head so a freshly reset FIFO presents zero rather than stale memory.
  assign out_data  = empty ? '0 : mem[rd_ptr];

  assign cap  = en & (~prev_vld | (ans != prev));
  assign pop  = out_valid & out_ready;
  assign push = cap & (~full | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= '0;
      prev_vld <= 1'b0;
    end else if (cap) begin
      // Updated even when the value is dropped, so a lost value is never retried.
      prev     <= ans;
      prev_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      drop <= cap & full & ~pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ans;
  end

`ifdef ANS_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  logic [15:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_cnt <= '0;
    else      ts_cnt <= ts_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) ts_mem[wr_ptr] <= ts_cnt;
  end

  assign out_ts = empty ? '0 : ts_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_mips_ans_monitor.sv
// Scoreboard bench for mips_ans_monitor: expected values are queued on capture and
// compared against out_data as the sink pops them.
module tb_mips_ans_monitor;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] ans;
  logic          en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          drop;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] m_prev;
  logic          m_pvld;

  mips_ans_monitor #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ans       (ans),
    .en        (en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict, advance, then compare the outcome.
  task automatic cycle(input logic [DW-1:0] a, input logic e, input logic r);
    logic m_cap, m_full, m_pop, m_push, m_drop;
    ans = a; en = e; out_ready = r;
    #1;
    m_cap  = e & (~m_pvld | (a != m_prev));
    m_full = (sb.size() == DEPTH);
    m_pop  = r & (sb.size() > 0);
    m_push = m_cap & (~m_full | m_pop);
    m_drop = m_cap & m_full & ~m_pop;
    if (m_pop) check("head", 32'(out_data), 32'(sb[0]));
    if (m_cap) begin
      m_prev = a;
      m_pvld = 1'b1;
    end
    @(posedge clk);
    #1;
    if (m_pop)  void'(sb.pop_front());
    if (m_push) sb.push_back(a);
    check("count", 32'(count), 32'(sb.size()));
    check("drop",  32'(drop),  32'(m_drop));
    check("valid", 32'(out_valid), 32'(sb.size() > 0));
    check("full",  32'(full),  32'(sb.size() == DEPTH));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"},  32'(full), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_data"},  32'(out_data), 32'd0);
    check({tag, "_drop"},  32'(drop), 32'd0);
  endtask

  initial begin
    rst = 1'b0; ans = '0; en = 1'b0; out_ready = 1'b0;
    m_prev = '0; m_pvld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b1;

    // Held value after reset is captured exactly once.
    repeat (4) cycle(16'h0000, 1'b1, 1'b0);
    check("t1_count", 32'(count), 32'd1);
    check("t1_data",  32'(out_data), 32'h0000);

    // Streaming with a ready sink.
    cycle(16'h0001, 1'b1, 1'b1);
    check("t2_d1", 32'(out_data), 32'h0001);
    cycle(16'h0002, 1'b1, 1'b1);
    check("t2_d2", 32'(out_data), 32'h0002);
    cycle(16'h0003, 1'b1, 1'b1);
    check("t2_d3", 32'(out_data), 32'h0003);
    check("t2_cnt", 32'(count), 32'd1);
    repeat (3) cycle(16'h0003, 1'b1, 1'b1);
    check("t2_empty", 32'(empty), 32'd1);

    // Overflow: nine distinct values into eight entries.
    for (int i = 0; i < 9; i++) cycle(16'(16'h0100 + i), 1'b1, 1'b0);
    check("t3_full", 32'(full), 32'd1);
    check("t3_count", 32'(count), 32'd8);
    check("t3_head", 32'(out_data), 32'h0100);

    // Full with simultaneous pop and push.
    cycle(16'h0200, 1'b1, 1'b1);
    check("t4_count", 32'(count), 32'd8);
    check("t4_drop", 32'(drop), 32'd0);
    check("t4_head", 32'(out_data), 32'h0101);
    repeat (10) cycle(16'h0200, 1'b1, 1'b1);
    check("t4_empty", 32'(empty), 32'd1);

    // Disabled capture holds the change detector.
    cycle(16'h00AA, 1'b1, 1'b1);
    cycle(16'h00AA, 1'b1, 1'b1);
    cycle(16'h00BB, 1'b0, 1'b1);
    cycle(16'h00AA, 1'b0, 1'b1);
    cycle(16'h00AA, 1'b1, 1'b1);
    check("t5_none", 32'(count), 32'd0);
    cycle(16'h00CC, 1'b1, 1'b0);
    check("t5_cc_cnt", 32'(count), 32'd1);
    check("t5_cc", 32'(out_data), 32'h00CC);
    cycle(16'h00CC, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cycle(16'($urandom_range(0, 5)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
    repeat (12) cycle(ans, 1'b0, 1'b1);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) cycle(16'(16'h0300 + i), 1'b1, 1'b0);
    check("t6_count5", 32'(count), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("t6");
    sb.delete();
    m_pvld = 1'b0; m_prev = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(16'h0304, 1'b1, 1'b0);
    check("t6_recap_cnt", 32'(count), 32'd1);
    check("t6_recap", 32'(out_data), 32'h0304);
    repeat (2) cycle(16'h0304, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
